// File: rtl/ppc_mbox_pkg.sv
// Shared register map and STATUS layout for the PPC mailbox.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ppc_mbox_pkg;

  // Word offsets decoded from addr[2:0]; offsets 4-7 are reserved
  typedef enum logic [2:0] {
    REG_TXDATA = 3'd0,
    REG_RXDATA = 3'd1,
    REG_STATUS = 3'd2,
    REG_IRQ_EN = 3'd3
  } mbox_reg_e;

  // STATUS bit positions
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_UDF     = 5;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;

endpackage

// File: rtl/mbox_fifo.sv
// Circular FIFO with head-of-queue data exposed combinationally from storage.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push ignored while full at cycle start; pop ignored while empty.
module mbox_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          push_dat,
  input  logic                   pop,
  output logic [DW-1:0]          head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Qualify requests against start-of-cycle state; pointers wrap modulo DEPTH
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; clearing the pointers discards its contents
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ppc_mailbox.sv
// CPU-facing mailbox: TX FIFO drained by the peer, RX FIFO filled by the peer, STATUS/IRQ_EN regs.
// Latency: register reads return one cycle after re_i; irq_o follows rx_empty/IRQ_EN by one cycle.
// Backpressure: in_ready drops when RX is full, out_valid drops when TX is empty; interrupt logic only with PPC_MBOX_IRQ_EN.
module ppc_mailbox
  import ppc_mbox_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [21:0]   addr,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          irq_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]    reg_off;
  logic          rd_act, tx_push, rx_pop, st_wr;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [DW-1:0] rx_head;
  logic [DW-1:0] status;

  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_udf_q, rx_udf_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;

  // Only the low three address bits select a register; the rest alias
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[21:3];

  // Bus decode: a write in the same cycle as a read wins and the read is dropped
  always_comb begin
    reg_off = addr[2:0];
    rd_act  = re_i & ~we_i;
    tx_push = we_i & (reg_off == REG_TXDATA);
    rx_pop  = rd_act & (reg_off == REG_RXDATA);
    st_wr   = we_i & (reg_off == REG_STATUS);
  end

  mbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .push_dat (wdata),
    .pop      (out_ready),
    .head_dat (out_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  mbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .push_dat (in_data),
    .pop      (rx_pop),
    .head_dat (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  assign in_ready  = ~rx_full;
  assign out_valid = ~tx_empty;

  // STATUS word assembled from live FIFO state and sticky flags
  always_comb begin
    status                          = '0;
    status[ST_TX_FULL]              = tx_full;
    status[ST_TX_EMPTY]             = tx_empty;
    status[ST_RX_FULL]              = rx_full;
    status[ST_RX_EMPTY]             = rx_empty;
    status[ST_TX_OVF]               = tx_ovf_q;
    status[ST_RX_UDF]               = rx_udf_q;
    status[ST_TX_CNT_LSB +: CW]     = tx_count;
    status[ST_RX_CNT_LSB +: CW]     = rx_count;
  end

  // Next-state for sticky flags, interrupt enable and the read-data register
  always_comb begin
    tx_ovf_d      = tx_ovf_q;
    rx_udf_d      = rx_udf_q;
    irq_en_d      = irq_en_q;
    irq_d         = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = rd_act;

    if (tx_push && tx_full)        tx_ovf_d = 1'b1;
    if (st_wr && wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (rx_pop && rx_empty)        rx_udf_d = 1'b1;
    if (st_wr && wdata[ST_RX_UDF]) rx_udf_d = 1'b0;

`ifdef PPC_MBOX_IRQ_EN
    if (we_i && (reg_off == REG_IRQ_EN)) irq_en_d = wdata[0];
    irq_d = irq_en_q & ~rx_empty;
`else
    irq_en_d = 1'b0;
`endif

    if (rd_act) begin
      rdata_d = '0;
      case (reg_off)
        REG_RXDATA: if (!rx_empty) rdata_d = rx_head;
        REG_STATUS: rdata_d = status;
        REG_IRQ_EN: rdata_d[0] = irq_en_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // Control registers; reset also kills a read issued in the reset cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q      <= 1'b0;
      rx_udf_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      tx_ovf_q      <= tx_ovf_d;
      rx_udf_q      <= rx_udf_d;
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_ppc_mailbox.sv
// Randomised plus directed bench for ppc_mailbox with a queue-based reference model.
// Driver updates the model and queues expected responses; a monitor compares them.
// Build with PPC_MBOX_IRQ_EN defined to exercise the interrupt path.
`timescale 1ns/1ps
module tb_ppc_mailbox;
  localparam int DEPTH = 16;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [21:0]   addr = '0;
  logic          re_i = 1'b0;
  logic          we_i = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          irq_o;

  ppc_mailbox #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .re_i        (re_i),
    .we_i        (we_i),
    .wdata       (wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain queues and counters
  typedef struct {
    logic [DW-1:0] val;
    int            at;
  } rd_t;

  logic [DW-1:0] m_rx[$];
  int            m_txn = 0;
  bit            m_ovf = 1'b0, m_udf = 1'b0, m_irqen = 1'b0, m_irq_exp = 1'b0;
  rd_t           exp_rd[$];
  logic [DW-1:0] exp_out[$];

  // One bus/peer cycle: check combinational outputs, advance the model, drive inputs
  task automatic step(input bit r, input bit re, input bit we, input logic [21:0] a,
                      input logic [DW-1:0] wd, input bit iv, input logic [DW-1:0] id,
                      input bit ordy);
    int            rxn, txn;
    bit            irqen_pre, rx_pop;
    logic [DW-1:0] v;
    @(negedge clk);
    rxn       = m_rx.size();
    txn       = m_txn;
    irqen_pre = m_irqen;
    if (chk_on) begin
      check("in_ready",  32'(in_ready),  32'(rxn < DEPTH));
      check("out_valid", 32'(out_valid), 32'(txn > 0));
      check("irq_o",     32'(irq_o),     32'(m_irq_exp));
    end
    if (r) begin
      m_rx.delete();
      exp_out.delete();
      m_txn = 0; m_ovf = 0; m_udf = 0; m_irqen = 0; m_irq_exp = 0;
      ordy = 1'b0;
    end else begin
      rx_pop = 1'b0;
      if (re && !we) begin
        v = '0;
        case (a[2:0])
          3'd1: if (rxn > 0) begin v = m_rx[0]; rx_pop = 1'b1; end else m_udf = 1'b1;
          3'd2: begin
            v[0] = (txn == DEPTH); v[1] = (txn == 0);
            v[2] = (rxn == DEPTH); v[3] = (rxn == 0);
            v[4] = m_ovf;          v[5] = m_udf;
            v[14:8]  = 7'(txn);
            v[22:16] = 7'(rxn);
          end
          3'd3: v[0] = m_irqen;
          default: v = '0;
        endcase
        exp_rd.push_back('{v, cyc + 1});
      end
      if (we) begin
        case (a[2:0])
          3'd0: if (txn == DEPTH) m_ovf = 1'b1;
                else begin exp_out.push_back(wd); m_txn++; end
          3'd2: begin
            if (wd[4]) m_ovf = 1'b0;
            if (wd[5]) m_udf = 1'b0;
          end
`ifdef PPC_MBOX_IRQ_EN
          3'd3: m_irqen = wd[0];
`endif
          default: ;
        endcase
      end
      if (ordy && txn > 0) m_txn--;
      if (rx_pop) void'(m_rx.pop_front());
      if (iv && rxn < DEPTH) m_rx.push_back(id);
`ifdef PPC_MBOX_IRQ_EN
      m_irq_exp = irqen_pre && (rxn > 0);
`else
      m_irq_exp = 1'b0;
`endif
    end
    rst = r; re_i = re; we_i = we; addr = a; wdata = wd;
    in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  task automatic wr(input logic [21:0] a, input logic [DW-1:0] d);
    step(0, 0, 1, a, d, 0, '0, 0);
  endtask
  task automatic rd(input logic [21:0] a);
    step(0, 1, 0, a, '0, 0, '0, 0);
  endtask
  task automatic peer_push(input logic [DW-1:0] d);
    step(0, 0, 0, '0, '0, 1, d, 0);
  endtask
  task automatic idle(input bit ordy);
    step(0, 0, 0, '0, '0, 0, '0, ordy);
  endtask

  // Monitor: compares read responses and TX pops against the queued expectations
  initial begin
    logic [DW-1:0] last;
    rd_t           e;
    bit            due;
    last = '0;
    forever begin
      @(negedge clk);
      #2;
      if (chk_on) begin
        due = (exp_rd.size() > 0) && (exp_rd[0].at == cyc);
        check("rdata_valid", 32'(rdata_valid), 32'(due));
        if (due) begin
          e = exp_rd.pop_front();
          check("rdata", rdata, e.val);
          last = e.val;
        end else begin
          check("rdata_hold", rdata, last);
          if (exp_rd.size() > 0 && exp_rd[0].at < cyc) void'(exp_rd.pop_front());
        end
        if (out_valid && out_ready) begin
          check("out_pop_expected", 32'(exp_out.size() > 0), 32'd1);
          if (exp_out.size() > 0) check("out_data", out_data, exp_out.pop_front());
        end
      end
      if (rst) last = '0;
    end
  end

  initial begin
    logic [21:0] a;
    // Reset state, then STATUS = tx_empty|rx_empty
    step(1, 0, 0, '0, '0, 0, '0, 0);
    step(1, 0, 0, '0, '0, 0, '0, 0);
    chk_on = 1'b1;
    rd(22'd2);
    idle(0);

    // TX ordering towards the peer
    wr(22'd0, 32'h11); wr(22'd0, 32'h22); wr(22'd0, 32'h33);
    repeat (5) idle(1);

    // TX overflow, sticky flag and clear; upper address bits alias
    for (int i = 0; i < DEPTH + 1; i++) wr(22'h3F_FF00 | 22'(i * 8), 32'h100 + 32'(i));
    rd(22'd2);
    wr(22'd2, 32'h10);
    rd(22'd2);
    repeat (DEPTH + 2) idle(1);
    rd(22'd2);

    // RX underflow, then one peer word
    rd(22'd1);
    rd(22'd2);
    peer_push(32'hA5A5);
    rd(22'd2);
    rd(22'd1);
    wr(22'd2, 32'h20);
    rd(22'd2);
    rd(22'd5); wr(22'd6, 32'hFFFF_FFFF); rd(22'd7);

    // Interrupt enable and level behaviour
    wr(22'd3, 32'd1);
    rd(22'd3);
    peer_push(32'hBEEF);
    idle(0); idle(0);
    rd(22'd1);
    idle(0); idle(0);
    wr(22'd3, 32'd0);

    // RX full: simultaneous read refuses the push, next cycle accepts it
    for (int i = 0; i < DEPTH; i++) peer_push(32'h200 + 32'(i));
    rd(22'd2);
    step(0, 1, 0, 22'd1, '0, 1, 32'h300, 0);
    step(0, 0, 0, '0, '0, 1, 32'h301, 0);
    rd(22'd2);

    // Read and write together: write only, no read pulse
    step(0, 1, 1, 22'd0, 32'h77, 0, '0, 0);
    idle(0);

    // Reset with a read in flight and data in both FIFOs
    wr(22'd0, 32'h55);
    step(1, 1, 0, 22'd1, '0, 1, 32'h66, 0);
    idle(0);
    rd(22'd2);
    idle(0);

    // Randomised traffic
    repeat (1500) begin
      a = 22'($urandom);
      a[2:0] = 3'($urandom_range(0, 7));
      step(0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), a, $urandom,
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
    end

    // Drain both sides and confirm nothing is left outstanding
    repeat (DEPTH + 2) idle(1);
    repeat (DEPTH + 2) rd(22'd1);
    rd(22'd2);
    idle(0); idle(0); idle(0);
    @(negedge clk);
    #4;
    check("tx_drained",   32'(exp_out.size()), 32'd0);
    check("reads_closed", 32'(exp_rd.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ppc_mailbox.md
PPC_MAILBOX -- requirements
Module: ppc_mailbox

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in 32-bit words (power of two, 4..64).
REQ-002 SHALL have parameter DW, default 32, data word width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  22  word address from the PPC bus interface stage.
REQ-006 SHALL have port re_i  input  1  one-cycle read strobe from the bus interface stage.
REQ-007 SHALL have port we_i  input  1  one-cycle write strobe from the bus interface stage.
REQ-008 SHALL have port wdata  input  DW  CPU write data, valid with we_i.
REQ-009 SHALL have port rdata  output  DW  registered read data.
REQ-010 SHALL have port rdata_valid  output  1  one-cycle pulse qualifying rdata.
REQ-011 SHALL have port in_valid / in_data / in_ready  input / input DW / output  peer-to-local push handshake.
REQ-012 SHALL have port out_valid / out_data / out_ready  output / output DW / input  local-to-peer pop handshake.
REQ-013 SHALL have port irq_o  output  1  level interrupt to the local CPU.

Function
REQ-014 SHALL decode addr[2:0] only (upper bits ignored, aliasing permitted): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 IRQ_EN; 4-7 read 0, writes ignored.
REQ-015 SHALL push wdata into TX FIFO on we_i to TXDATA when not full; when full, drop the word and set sticky TX_OVF.
REQ-016 SHALL pop RX FIFO on re_i to RXDATA when not empty, returning the head word; when empty, return 0 and set sticky RX_UDF.
REQ-017 SHALL return STATUS as bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 TX_OVF, bit5 RX_UDF, [14:8] tx_count, [22:16] rx_count, others 0.
REQ-018 SHALL clear TX_OVF/RX_UDF when STATUS is written with 1 in bit4/bit5; write-0 bits unchanged.
REQ-019 SHALL present rdata and rdata_valid exactly one cycle after re_i; rdata holds until next read.
REQ-020 SHALL, when re_i and we_i coincide, perform the write only and not pulse rdata_valid.
REQ-021 SHALL drive in_ready = !rx_full and accept in_data when in_valid & in_ready.
REQ-022 SHALL drive out_valid = !tx_empty, out_data = TX head (combinational from storage), pop on out_valid & out_ready.
REQ-023 SHALL allow same-cycle push and pop on one FIFO; count unchanged, data order preserved; push still refused if full at cycle start.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; counts range 0..DEPTH.
REQ-025 SHALL update irq_o registered, one cycle after rx_empty or IRQ_EN bit0 changes: irq_o = IRQ_EN[0] & !rx_empty.

Reset
REQ-026 SHALL on rst: empty both FIFOs, clear pointers, counts, TX_OVF, RX_UDF, IRQ_EN; rdata=0, rdata_valid=0, irq_o=0, in_ready=1, out_valid=0.
REQ-027 SHALL abort any in-flight read on rst (no rdata_valid pulse after reset), discarding FIFO contents.

Configuration
REQ-028 SHALL implement interrupt logic only when PPC_MBOX_IRQ_EN is defined; otherwise irq_o tied 0, IRQ_EN reads 0 and writes ignored.

Structure
REQ-029 SHALL take register offsets (0-3) and STATUS bit positions from shared package ppc_mbox_pkg.
REQ-030 SHALL instantiate sub-module mbox_fifo (parameterised DEPTH/DW, push/pop, full/empty/count) twice: TX and RX.

Verification
REQ-031 Reset, then read STATUS -> rdata=0x0000_000A (tx_empty, rx_empty), rdata_valid one cycle after re_i.
REQ-032 Write 0x11,0x22,0x33 to TXDATA, then out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, then out_valid=0.
REQ-033 Write DEPTH+1 words to TXDATA -> tx_full=1, TX_OVF=1, last word dropped; write STATUS 0x10 -> TX_OVF=0.
REQ-034 Read RXDATA when empty -> rdata=0, RX_UDF=1; peer pushes 0xA5A5 -> rx_count=1, read returns 0xA5A5.
REQ-035 With PPC_MBOX_IRQ_EN: IRQ_EN=1, peer push -> irq_o=1 one cycle later; read RXDATA -> irq_o=0; without macro irq_o stays 0.
REQ-036 RX full with in_valid=1 and simultaneous RXDATA read -> push refused that cycle, accepted next cycle, rx_count returns to DEPTH.
